// File: rtl/sb_rx.sv
// -----------------------------------------------------------------------------
// sb_rx : UCIe logical PHY sideband serial receiver
//
// Purpose
//   Deserialises 64-bit sideband packets arriving on a source-synchronous
//   data / forwarded-clock pin pair. It queues completed packets in a
//   buffer_size-deep FIFO in the clk_100MHz domain. The upper layer reads the
//   FIFO through a valid/request pop handshake.
//
// Ports
//   clk_100MHz  in   protocol-side clock (FIFO, handshake)
//   clk_800MHz  in   sideband UI reference clock, unused by the core logic
//   reset       in   asynchronous, active-high; clears every domain
//   enable_i    in   receiver enable (clk_100MHz domain)
//   msg_req_i   in   upper-layer pop request (clk_100MHz domain)
//   dataPin_i   in   serial sideband data, LSB first
//   clkPin_i    in   forwarded sideband clock; idle low, one rising edge per bit
//   data_o      out  [63:0] packet at FIFO head, 64'h0 while empty
//   valid_o     out  FIFO non-empty and receiver enabled
//
// Handshake
//   valid_o / msg_req_i behave as valid/ready. A pop happens on every
//   clk_100MHz rising edge where valid_o && msg_req_i. The consumer takes
//   data_o on that same edge. valid_o never depends combinationally on
//   msg_req_i.
// -----------------------------------------------------------------------------
module sb_rx #(
  parameter int buffer_size = 4
) (
  input  logic        clk_100MHz,
  input  logic        clk_800MHz,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        msg_req_i,
  input  logic        dataPin_i,
  input  logic        clkPin_i,
  output logic [63:0] data_o,
  output logic        valid_o
);

  localparam int AW = $clog2(buffer_size);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // The UI reference clock is kept on the port list for the peer's pinout only.
  logic w_unused_clk;
  assign w_unused_clk = clk_800MHz;

  // ---------------------------------------------------------------------------
  // Deserialiser, forwarded-clock domain
  // ---------------------------------------------------------------------------
  logic [63:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [63:0] r_capture;
  logic        r_pkt_toggle;
  logic [63:0] w_shift_next;

  assign w_shift_next = {dataPin_i, r_shift[63:1]};

  always_ff @(posedge clkPin_i or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_capture    <= '0;
      r_pkt_toggle <= 1'b0;
    end else begin
      r_shift   <= w_shift_next;
      // The counter is 6 bits wide, so it wraps to 0 after the 64th bit.
      r_bit_cnt <= r_bit_cnt + 6'd1;
      if (r_bit_cnt == 6'd63) begin
        r_capture    <= w_shift_next;
        r_pkt_toggle <= ~r_pkt_toggle;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Toggle synchroniser and edge detector, clk_100MHz domain.
  // r_capture is not synchronised. It stays frozen for at least 96 UI after
  // the toggle, which is far longer than the 2-3 cycle push latency.
  // ---------------------------------------------------------------------------
  logic r_tog_meta;
  logic r_tog_sync;
  logic r_tog_prev;
  logic w_push_pulse;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_tog_meta <= 1'b0;
      r_tog_sync <= 1'b0;
      r_tog_prev <= 1'b0;
    end else begin
      r_tog_meta <= r_pkt_toggle;
      r_tog_sync <= r_tog_meta;
      r_tog_prev <= r_tog_sync;
    end
  end

  assign w_push_pulse = r_tog_sync ^ r_tog_prev;

  // ---------------------------------------------------------------------------
  // FIFO. The pointers are one bit wider than the address so that full and
  // empty can be told apart.
  // ---------------------------------------------------------------------------
  logic [63:0] r_mem [buffer_size];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign valid_o = !w_empty && enable_i;
  assign data_o  = w_empty ? 64'h0 : r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = valid_o && msg_req_i;
  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // accept the arriving packet.
  assign w_push = w_push_pulse && enable_i && (!w_full || w_pop);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // The storage needs no reset. data_o masks it while the FIFO is empty.
  always_ff @(posedge clk_100MHz) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_capture;
    end
  end

endmodule

// File: tb/tb_sb_rx.sv
`timescale 1ns/1ps
module tb_sb_rx;

  localparam int BUF = 4;

  logic        clk_100MHz = 1'b0;
  logic        clk_800MHz = 1'b0;
  logic        reset      = 1'b1;
  logic        enable_i   = 1'b0;
  logic        msg_req_i  = 1'b0;
  logic        dataPin_i  = 1'b0;
  logic        clkPin_i   = 1'b0;
  logic [63:0] data_o;
  logic        valid_o;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  int          n_checks = 0;
  int          n_pass   = 0;

  sb_rx #(.buffer_size(BUF)) dut (
    .clk_100MHz (clk_100MHz),
    .clk_800MHz (clk_800MHz),
    .reset      (reset),
    .enable_i   (enable_i),
    .msg_req_i  (msg_req_i),
    .dataPin_i  (dataPin_i),
    .clkPin_i   (clkPin_i),
    .data_o     (data_o),
    .valid_o    (valid_o)
  );

  // ---------------------------------------------------------------- clocks
  always #5     clk_100MHz = ~clk_100MHz;
  always #0.625 clk_800MHz = ~clk_800MHz;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  // Inputs change only at posedge+1, so the values seen at a negedge are
  // exactly the values the next posedge acts on.
  always @(negedge clk_100MHz) begin
    if (!reset && valid_o && msg_req_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: data_o=%h popped, no packet expected", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o !== mon_exp)
          $display("FAIL pop_data: data_o=%h expected=%h", data_o, mon_exp);
        else
          n_pass++;
      end
    end
  end

  // --------------------------------------------------------------- drivers
  // Each bit is launched half a UI (800 MHz) before its capturing rising edge.
  task automatic send_bits(input logic [63:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dataPin_i = w[i];
      #0.625 clkPin_i = 1'b1;
      #0.625 clkPin_i = 1'b0;
    end
  endtask

  task automatic set_ctrl(input logic en, input logic req);
    @(posedge clk_100MHz);
    #1;
    enable_i  = en;
    msg_req_i = req;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_100MHz);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; enable_i = 1'b1; msg_req_i = 1'b1;
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: valid_o=%b expected=0", valid_o); else n_pass++;
    n_checks++;
    if (data_o !== 64'h0) $display("FAIL reset_data: data_o=%h expected=0", data_o); else n_pass++;
    // Clock edges during reset must never frame a packet.
    send_bits(rand64(), 64);
    send_bits(rand64(), 10);
    @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL reset_toggle_valid: valid_o=%b expected=0", valid_o); else n_pass++;
    #3 reset = 1'b0;
    repeat (10) @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== 64'h0)
      $display("FAIL post_reset: valid_o=%b data_o=%h expected 0/0", valid_o, data_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
    logic [63:0] words [3];
    int  n;
    bit  ok;
    words[0] = w0; words[1] = w1; words[2] = w2;
    set_ctrl(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(words[k]);
      send_bits(words[k], 64);
      n = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk_100MHz);
        n = c;
        if (valid_o) break;
      end
      n_checks++;
      if (!valid_o || n > 4)
        $display("FAIL b2b_latency: valid_o seen after %0d cycles (valid_o=%b), expected within 4", n, valid_o);
      else n_pass++;
      #40;
    end
    drain(ok);
    @(negedge clk_100MHz);
    n_checks++;
    if (!ok || valid_o !== 1'b0)
      $display("FAIL b2b_drain: left=%0d valid_o=%b expected 0/0", exp_q.size(), valid_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] w;
    bit ok;
    set_ctrl(1'b1, 1'b0);
    for (int k = 0; k < BUF + 1; k++) begin
      w = rand64();
      if (k < BUF) exp_q.push_back(w);
      send_bits(w, 64);
      #40;
    end
    repeat (4) @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b1) $display("FAIL ovf_valid: valid_o=%b expected=1", valid_o); else n_pass++;
    n_checks++;
    if (data_o !== exp_q[0]) $display("FAIL ovf_head: data_o=%h expected=%h", data_o, exp_q[0]); else n_pass++;
    set_ctrl(1'b1, 1'b1);
    drain(ok);
    repeat (2) @(negedge clk_100MHz);
    n_checks++;
    if (!ok || valid_o !== 1'b0 || data_o !== 64'h0)
      $display("FAIL ovf_drain: left=%0d valid_o=%b data_o=%h expected 0/0/0", exp_q.size(), valid_o, data_o);
    else n_pass++;
  endtask

  task automatic test_disable();
    logic [63:0] w;
    bit seen;
    bit ok;
    set_ctrl(1'b0, 1'b1);
    send_bits(64'hFEEDBEEFCAFEBABE, 64);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk_100MHz);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL dis_valid: valid_o=1 while disabled, expected=0"); else n_pass++;
    set_ctrl(1'b1, 1'b1);
    repeat (3) @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL dis_dropped: valid_o=%b data_o=%h expected 0", valid_o, data_o); else n_pass++;
    w = rand64();
    exp_q.push_back(w);
    send_bits(w, 64);
    #40;
    drain(ok);
    n_checks++;
    if (!ok) $display("FAIL dis_next: %0d packet(s) not delivered, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_ctrl(1'b1, 1'b1);
    send_bits(64'hA5A5_5A5A_C3C3_3C3C, 30);
    #2  reset = 1'b1;
    #20 reset = 1'b0;
    #20;
    exp_q.push_back(64'h1234567890ABCDEF);
    send_bits(64'h1234567890ABCDEF, 64);
    #40;
    drain(ok);
    repeat (3) @(negedge clk_100MHz);
    n_checks++;
    if (!ok || valid_o !== 1'b0)
      $display("FAIL mid_reset: left=%0d valid_o=%b expected 0/0", exp_q.size(), valid_o);
    else n_pass++;
  endtask

  task automatic test_full_pop_push();
    logic [63:0] w;
    bit ok;
    set_ctrl(1'b1, 1'b0);
    for (int k = 0; k < BUF; k++) begin
      w = rand64();
      exp_q.push_back(w);
      send_bits(w, 64);
      #40;
    end
    repeat (4) @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b1) $display("FAIL fp_full_valid: valid_o=%b expected=1", valid_o); else n_pass++;
    // Align the 64th clkPin_i edge to posedge+2 ns. The push then lands on the
    // third clk_100MHz posedge after it. Raise msg_req_i for that edge only.
    w = rand64();
    exp_q.push_back(w);
    @(posedge clk_100MHz);
    #2.625;
    send_bits(w, 64);
    @(posedge clk_100MHz);
    @(posedge clk_100MHz);
    #1 msg_req_i = 1'b1;
    @(posedge clk_100MHz);
    #1 msg_req_i = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== exp_q[0])
      $display("FAIL fp_head: valid_o=%b data_o=%h expected 1/%h", valid_o, data_o, exp_q[0]);
    else n_pass++;
    set_ctrl(1'b1, 1'b1);
    drain(ok);
    repeat (2) @(negedge clk_100MHz);
    n_checks++;
    if (!ok || valid_o !== 1'b0)
      $display("FAIL fp_occupancy: left=%0d valid_o=%b expected 0/0", exp_q.size(), valid_o);
    else n_pass++;
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_back_to_back(64'hF0AABBCC1122330F, 64'h1234567890ABCDEF, 64'hFEEDBEEFCAFEBABE);
    test_overflow();
    test_disable();
    test_reset_mid();
    test_full_pop_push();
    test_back_to_back(rand64(), rand64(), rand64());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
